// File: rtl/mux_2_1_sel_arb.sv
// Two-requester round-robin arbiter driving the select line of a 2:1 mux.
// Define ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST transfers.
module mux_2_1_sel_arb #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic             valid,
    output logic [CNT_W-1:0] burst_cnt
);

    // One-hot grant encoding so gnt_a/gnt_b come straight off flops.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    if (MAX_BURST < 1 || MAX_BURST > (2 ** CNT_W) - 1) begin : g_bad_max_burst
        $error("MAX_BURST out of range for CNT_W");
    end

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   s_q, s_d;
    logic   xfer;
    logic   keep;

    function automatic state_t arb(input logic ra, input logic rb, input logic lst);
        if (ra && rb) return (lst == SRC_B) ? GRANT_A : GRANT_B;
        else if (ra)  return GRANT_A;
        else if (rb)  return GRANT_B;
        else          return IDLE;
    endfunction

    assign xfer = (state_q != IDLE) && ready;

`ifdef ARB_BURST_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             room;

    assign room = ({1'b0, cnt_q} + 1'b1) < (CNT_W + 1)'(MAX_BURST);
`else
    logic room;

    assign room = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        keep    = 1'b0;
        case (state_q)
            IDLE: state_d = arb(req_a, req_b, last_q);
            GRANT_A: begin
                if (xfer) begin
                    last_d = SRC_A;
                    if (req_a && room) keep = 1'b1;
                    else state_d = arb(req_a, req_b, SRC_A);
                end else if (!req_a) begin
                    state_d = IDLE;
                end
            end
            GRANT_B: begin
                if (xfer) begin
                    last_d = SRC_B;
                    if (req_b && room) keep = 1'b1;
                    else state_d = arb(req_a, req_b, SRC_B);
                end else if (!req_b) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // In IDLE the select parks on whatever it last pointed at.
        s_d = s_q;
        if (state_d == GRANT_A) s_d = 1'b0;
        else if (state_d == GRANT_B) s_d = 1'b1;
    end

`ifdef ARB_BURST_EN
    always_comb begin
        cnt_d = cnt_q;
        if (keep)                 cnt_d = cnt_q + 1'b1;
        else if (xfer)            cnt_d = '0;
        else if (state_d == IDLE) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign burst_cnt = cnt_q;
`else
    assign burst_cnt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC_B;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
        end
    end

    assign gnt_a = state_q[0];
    assign gnt_b = state_q[1];
    assign valid = state_q[0] | state_q[1];
    assign s     = s_q;

endmodule

// File: tb/tb_mux_2_1_sel_arb.sv
// Directed bench for mux_2_1_sel_arb: reset, round-robin ties, backpressure,
// lone requester, protocol violation and (with ARB_BURST_EN) burst grants.
module tb_mux_2_1_sel_arb;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       ready;
    logic       gnt_a;
    logic       gnt_b;
    logic       s;
    logic       valid;
    logic [2:0] burst_cnt;

    int total = 0;
    int bad   = 0;

    mux_2_1_sel_arb #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .ready     (ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .s         (s),
        .valid     (valid),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs packed as {gnt_a, gnt_b, s, valid}.
    localparam logic [3:0] O_IDLE_S0 = 4'b0000;
    localparam logic [3:0] O_IDLE_S1 = 4'b0010;
    localparam logic [3:0] O_A       = 4'b1001;
    localparam logic [3:0] O_B       = 4'b0111;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a = 1'b0;
        req_b = 1'b0;
        ready = 1'b0;
        rst   = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt_a, gnt_b, s, valid, burst_cnt} !== {O_IDLE_S0, 3'd0}) begin
            bad++;
            $display("FAIL reset_values got=%b want=%b", {gnt_a, gnt_b, s, valid, burst_cnt}, {O_IDLE_S0, 3'd0});
        end
        req_a = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_before_edge valid got=%b want=0", valid);
        end
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_A) begin
            bad++;
            $display("FAIL first_grant got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_A);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({gnt_a, gnt_b, s, valid, burst_cnt} !== {O_IDLE_S0, 3'd0}) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", {gnt_a, gnt_b, s, valid, burst_cnt}, {O_IDLE_S0, 3'd0});
        end
        #2;
        rst = 1'b0;
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_A) begin
            bad++;
            $display("FAIL grant_after_release got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_A);
        end
    endtask

    task automatic test_tie();
        logic [3:0] exp_seq [6];
        exp_seq = '{O_A, O_B, O_A, O_B, O_A, O_B};
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if ({gnt_a, gnt_b, s, valid, burst_cnt} !== {exp_seq[i], 3'd0}) begin
                bad++;
                $display("FAIL tie_word%0d got=%b want=%b", i, {gnt_a, gnt_b, s, valid, burst_cnt}, {exp_seq[i], 3'd0});
            end
        end
    endtask

    // Continues from the GRANT_B state left by test_tie.
    task automatic test_backpressure();
        ready = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({gnt_a, gnt_b, s, valid} !== O_B) begin
                bad++;
                $display("FAIL backpressure_hold%0d got=%b want=%b", i, {gnt_a, gnt_b, s, valid}, O_B);
            end
        end
        ready = 1'b1;
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_A) begin
            bad++;
            $display("FAIL backpressure_release got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_A);
        end
    endtask

    task automatic test_lone();
        int xfers;
        do_reset();
        req_b = 1'b1;
        ready = 1'b1;
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_B) begin
            bad++;
            $display("FAIL lone_grant got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_B);
        end
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid && ready) xfers++;
            step();
            total++;
            if ({gnt_a, gnt_b, s, valid} !== O_B) begin
                bad++;
                $display("FAIL lone_hold%0d got=%b want=%b", i, {gnt_a, gnt_b, s, valid}, O_B);
            end
        end
        total++;
        if (xfers != 4) begin
            bad++;
            $display("FAIL lone_xfer_count got=%0d want=4", xfers);
        end
        req_b = 1'b0;
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_IDLE_S1) begin
            bad++;
            $display("FAIL lone_drop got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_IDLE_S1);
        end
    endtask

    task automatic test_violation();
        do_reset();
        req_a = 1'b1;
        ready = 1'b0;
        step();
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_A) begin
            bad++;
            $display("FAIL violation_hold got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_A);
        end
        req_a = 1'b0;
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_IDLE_S0) begin
            bad++;
            $display("FAIL violation_idle got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_IDLE_S0);
        end
        // No transfer happened, so the pointer still favours A on a tie.
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        total++;
        if ({gnt_a, gnt_b, s, valid} !== O_A) begin
            bad++;
            $display("FAIL violation_tie got=%b want=%b", {gnt_a, gnt_b, s, valid}, O_A);
        end
    endtask

`ifdef ARB_BURST_EN
    task automatic test_burst();
        logic [3:0] exp_o [8];
        logic [2:0] exp_c [8];
        exp_o = '{O_A, O_A, O_A, O_A, O_B, O_B, O_B, O_B};
        exp_c = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if ({gnt_a, gnt_b, s, valid, burst_cnt} !== {exp_o[i], exp_c[i]}) begin
                bad++;
                $display("FAIL burst_word%0d got=%b want=%b", i, {gnt_a, gnt_b, s, valid, burst_cnt}, {exp_o[i], exp_c[i]});
            end
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        ready = 1'b0;
        test_reset();
`ifdef ARB_BURST_EN
        test_burst();
`else
        test_tie();
        test_backpressure();
`endif
        test_lone();
        test_violation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_2_1_sel_arb.md
# mux_2_1_sel_arb

Two-requester round-robin arbiter that sits directly upstream of the 2:1 mux and drives its select line `s`. Two sources raise requests; the block grants one at a time, drives `s` so the mux forwards the granted source, and presents `valid` to the downstream consumer. A grant is held until the consumer accepts the word with `ready`. Grant, select and valid are all registered, so the mux select is glitch-free.

## Interface
- `MAX_BURST`, default 4: maximum consecutive transfers per grant when burst mode is compiled in. Legal range 1..2^`CNT_W`-1.
- `CNT_W`, default 3: width of the burst counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_a`  in  1  source A (mux input `a`) has a word.
- `req_b`  in  1  source B (mux input `b`) has a word.
- `ready`  in  1  downstream accepts the mux output this cycle.
- `gnt_a`  out  1  source A granted; its word is on the mux output.
- `gnt_b`  out  1  source B granted.
- `s`  out  1  mux select: 0 selects `a`, 1 selects `b`.
- `valid`  out  1  mux output carries a granted word.
- `burst_cnt`  out  `CNT_W`  transfers completed in the current grant. Always 0 when `ARB_BURST_EN` is undefined.

## Operation
- States: IDLE, GRANT_A, GRANT_B. `valid` = (state != IDLE). `gnt_a`/`gnt_b` are one-hot or both 0.
- Transfer: `valid` && `ready` at a rising edge.
- Internal pointer `last` holds the most recently granted source. Reset value is B, so A wins the first tie.
- IDLE: only `req_a` -> GRANT_A; only `req_b` -> GRANT_B; both -> the source != `last`; neither -> stay.
- GRANT_x without transfer: hold state, `s` and grant unchanged. A grant never moves mid-handshake.
- GRANT_x with `req_x` dropped before transfer: protocol violation; go to IDLE next edge. `last` is unchanged.
- GRANT_x with transfer:
  - `last` <= x.
  - Re-arbitrate on the requests sampled at that same edge, using the IDLE rules with the updated `last`.
  - Back-to-back words therefore alternate when both sources request; a lone requester keeps the grant with no bubble.
- `s` follows the granted source. In IDLE `s` holds its previous value.
- Sources must hold `req_x` high until their transfer completes.

## Timing
- Reset values: state IDLE, `gnt_a`=0, `gnt_b`=0, `valid`=0, `s`=0, `burst_cnt`=0, `last`=B.
- Reset assertion clears all outputs immediately, regardless of the clock. Mid-handshake this drops the word; no transfer is counted.
- Latency: request high at edge N -> grant, `s` and `valid` high after edge N (visible in cycle N+1).
- Sustained throughput: one transfer per cycle while requests persist and `ready` is held high.
- Grant release: after the transfer edge, the grant switches or drops on that same edge.

## Configuration
- `ARB_BURST_EN` defined:
  - After a transfer, the owner keeps the grant while its request stays high and `burst_cnt`+1 < `MAX_BURST`, even if the other source requests.
  - `burst_cnt` increments per transfer and clears on a grant change or on IDLE.
  - Once `MAX_BURST` transfers are reached, the standard round-robin rule applies and the counter clears.
- `ARB_BURST_EN` undefined:
  - Strict per-word alternation as in Operation.
  - Burst counter logic is removed; `burst_cnt` is tied to 0.

## Test plan
- Reset: assert `rst` mid-cycle with `req_a`=1 -> all outputs 0 immediately. Release with only `req_a`=1 -> after the next edge `gnt_a`=1, `s`=0, `valid`=1.
- Tie after reset: `req_a`=`req_b`=1, `ready`=1 for 6 cycles, burst off -> grants A,B,A,B,A,B; `s` = 0,1,0,1,0,1.
- Backpressure: GRANT_B with `ready`=0 for 5 cycles while `req_a`=1 -> `s`=1 and `gnt_b`=1 held all 5 cycles. On the first `ready`=1 edge, switch to A.
- Lone requester: only `req_b`=1, `ready`=1 for 4 cycles -> `gnt_b` stays high, 4 transfers, no idle cycle. Drop `req_b` -> IDLE next edge, `valid`=0, `s` stays 1.
- Protocol violation: drop `req_a` while granted with `ready`=0 -> IDLE next edge, `last` unchanged. A subsequent tie grants A again.
- Burst (`ARB_BURST_EN`, `MAX_BURST`=4): both requesting, `ready`=1 -> A,A,A,A,B,B,B,B; `burst_cnt` = 0,1,2,3,0,1,2,3.
